// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and defaults for the RAM arbiter between program loader and CPU core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Bus owner; gnt0/gnt1 decode directly from this.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    // Requester identities.
    localparam int REQ_LOADER = 0;
    localparam int REQ_CPU    = 1;

    // Default geometry and fairness limit.
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles both requester ports and the RAM macro port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until granted; grant is the only stall signal.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Requester 0 (loader) and requester 1 (CPU)
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;

    // RAM macro side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus RAM: everything around the arbiter.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // The arbiter itself.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Purpose: two-requester single-port RAM arbiter (loader = 0, CPU = 1) with burst limit; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: grant 1 cycle after request from IDLE; single-cycle transfers; read data 1 cycle after transfer.
// Backpressure: a requester stalls (holds req) until its registered grant; owner yields after MAX_BURST transfers under contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    owner_e            state_q, state_d;
    owner_e            tie_owner;
    logic [3:0]        burst_q, burst_d;
    logic              gnt0, gnt1;
    logic              xfer0, xfer1;
    logic              rv0_q, rv1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign gnt0  = (state_q == OWN0);
    assign gnt1  = (state_q == OWN1);
    assign xfer0 = bus.req0 & gnt0;
    assign xfer1 = bus.req1 & gnt1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // Track the most recent owner so a simultaneous request from IDLE goes to the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'(REQ_CPU);
        end else if (state_d == OWN0) begin
            last_q <= 1'(REQ_LOADER);
        end else if (state_d == OWN1) begin
            last_q <= 1'(REQ_CPU);
        end
    end

    assign tie_owner = (last_q == 1'(REQ_LOADER)) ? OWN1 : OWN0;
`else
    // Fixed priority: the loader always wins a tie.
    assign tie_owner = OWN0;
`endif

    // Owner state and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Next owner and burst count; the last allowed transfer under contention hands over with no dead cycle.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) state_d = tie_owner;
                else if (bus.req0)        state_d = OWN0;
                else if (bus.req1)        state_d = OWN1;
            end
            OWN0: begin
                if (!bus.req0)                             state_d = bus.req1 ? OWN1 : IDLE;
                else if (bus.req1 && burst_q == BURST_LAST) state_d = OWN1;
            end
            OWN1: begin
                if (!bus.req1)                             state_d = bus.req0 ? OWN0 : IDLE;
                else if (bus.req0 && burst_q == BURST_LAST) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        // A lone owner saturates the count so it keeps the bus until someone else asks.
        if (state_d != state_q) begin
            burst_d = '0;
        end else if ((xfer0 || xfer1) && burst_q != BURST_LAST) begin
            burst_d = burst_q + 4'd1;
        end
    end

    // RAM command mux from the current transferring owner; all zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer0) begin
            mem_we    = bus.we0;
            mem_addr  = bus.addr0;
            mem_wdata = bus.wdata0;
        end else if (xfer1) begin
            mem_we    = bus.we1;
            mem_addr  = bus.addr1;
            mem_wdata = bus.wdata1;
        end
    end

    // Return tag: remembers who issued the read so the data goes back to them even across a handover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= xfer0 & ~bus.we0;
            rv1_q <= xfer1 & ~bus.we1;
        end
    end

    // Hold the last returned word so rdata stays stable between read returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rv0_q || rv1_q) begin
            rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = rv0_q;
    assign bus.rvalid1   = rv1_q;
    assign bus.rdata     = (rv0_q || rv1_q) ? bus.mem_rdata : rdata_q;
    assign bus.mem_en    = xfer0 | xfer1;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: vector table, corner sequences, random run against a reference model.
// Latency: checks outputs at the falling edge of each cycle.
// Backpressure: requesters hold req; model predicts grants and hand-overs.
module tb_mem_arbiter;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM behavioural model: synchronous write, registered read.
    logic [7:0] ram [16];
    logic [7:0] mem_rdata_r;
    logic       preloaded = 1'b0;

    function automatic logic [7:0] ram_init(input int i);
        return (i == 3) ? 8'hA5 : 8'(i * 37 + 5);
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= ram_init(i);
            preloaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rdata_r       <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    typedef struct {
        logic       r0, w0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic       g0, g1, en, mwe;
        logic [3:0] ma;
        logic [7:0] md;
        logic       rv0, rv1;
        logic [7:0] rd;
    } vec_t;

    function automatic vec_t v(int r0, int w0, int a0, int d0, int r1, int w1, int a1, int d1,
                               int g0, int g1, int en, int mwe, int ma, int md,
                               int rv0, int rv1, int rd);
        vec_t x;
        x.r0 = 1'(r0);  x.w0 = 1'(w0);  x.a0 = 4'(a0);  x.d0 = 8'(d0);
        x.r1 = 1'(r1);  x.w1 = 1'(w1);  x.a1 = 4'(a1);  x.d1 = 8'(d1);
        x.g0 = 1'(g0);  x.g1 = 1'(g1);  x.en = 1'(en);  x.mwe = 1'(mwe);
        x.ma = 4'(ma);  x.md = 8'(md);
        x.rv0 = 1'(rv0); x.rv1 = 1'(rv1); x.rd = 8'(rd);
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with both requesters asserting; nothing may leak out.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt0", int'(bus.gnt0), 0);
            chk("rst_gnt1", int'(bus.gnt1), 0);
            chk("rst_rvalid", int'(bus.rvalid0 | bus.rvalid1), 0);
            chk("rst_mem_en", int'(bus.mem_en), 0);
            chk("rst_rdata", int'(bus.rdata), 0);
        end
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        rst_n = 1'b1;
    endtask

    // Reference model state (owner -1 = nobody)
    int         m_owner, m_run, m_last, m_pend;
    logic [7:0] m_pdata, m_hold;
    logic [7:0] shadow [16];

    vec_t tbl [12];

    initial begin
        int own, prev;
        bit rr;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        rst_n = 1'b0;
        step();
        do_reset();

        // Lone CPU read of address 3, then a six-word loader write burst.
        tbl[0]  = v(0,0,0,0,     1,0,3,0, 0,0,0,0,0,0, 0,0,8'h00);
        tbl[1]  = v(0,0,0,0,     1,0,3,0, 0,1,1,0,3,0, 0,0,8'h00);
        tbl[2]  = v(0,0,0,0,     0,0,0,0, 0,1,0,0,0,0, 0,1,8'hA5);
        tbl[3]  = v(1,1,0,8'h11, 0,0,0,0, 0,0,0,0,0,0, 0,0,8'hA5);
        for (int k = 0; k < 6; k++)
            tbl[4+k] = v(1,1,k,8'h11+k, 0,0,0,0, 1,0,1,1,k,8'h11+k, 0,0,8'hA5);
        tbl[10] = v(0,0,0,0,     0,0,0,0, 1,0,0,0,0,0, 0,0,8'hA5);
        tbl[11] = v(0,0,0,0,     0,0,0,0, 0,0,0,0,0,0, 0,0,8'hA5);

        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].r0, tbl[r].w0, tbl[r].a0, tbl[r].d0, tbl[r].r1, tbl[r].w1, tbl[r].a1, tbl[r].d1);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", r), int'(bus.gnt0), int'(tbl[r].g0));
            chk($sformatf("tbl%0d_gnt1", r), int'(bus.gnt1), int'(tbl[r].g1));
            chk($sformatf("tbl%0d_mem_en", r), int'(bus.mem_en), int'(tbl[r].en));
            chk($sformatf("tbl%0d_mem_we", r), int'(bus.mem_we), int'(tbl[r].mwe));
            chk($sformatf("tbl%0d_mem_addr", r), int'(bus.mem_addr), int'(tbl[r].ma));
            chk($sformatf("tbl%0d_mem_wdata", r), int'(bus.mem_wdata), int'(tbl[r].md));
            chk($sformatf("tbl%0d_rvalid0", r), int'(bus.rvalid0), int'(tbl[r].rv0));
            chk($sformatf("tbl%0d_rvalid1", r), int'(bus.rvalid1), int'(tbl[r].rv1));
            chk($sformatf("tbl%0d_rdata", r), int'(bus.rdata), int'(tbl[r].rd));
            step();
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("ram%0d", k), int'(ram[k]), 8'h11 + k);

        // Contention from reset: loader first, ownership flips every MB transfers, no idle cycle.
        do_reset();
        drive(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("cont_idle_gnt", int'(bus.gnt0 | bus.gnt1), 0);
            end else begin
                own = ((c - 1) / MB) % 2;
                chk($sformatf("cont%0d_gnt0", c), int'(bus.gnt0), int'(own == 0));
                chk($sformatf("cont%0d_gnt1", c), int'(bus.gnt1), int'(own == 1));
                chk($sformatf("cont%0d_mem_en", c), int'(bus.mem_en), 1);
            end
            if (c >= 2) begin
                prev = ((c - 2) / MB) % 2;
                chk($sformatf("cont%0d_rvalid0", c), int'(bus.rvalid0), int'(prev == 0));
                chk($sformatf("cont%0d_rvalid1", c), int'(bus.rvalid1), int'(prev == 1));
            end
            step();
        end

        // Tie-break after the loader was the last owner.
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        step(); step();
        bus.req0 = 1'b1;
        step(); step(); step();
        bus.req0 = 1'b0;
        step(); step();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        chk("tie_idle_gnt", int'(bus.gnt0 | bus.gnt1), 0);
        step();
        @(negedge clk);
        chk("tie_gnt0", int'(bus.gnt0), rr ? 0 : 1);
        chk("tie_gnt1", int'(bus.gnt1), rr ? 1 : 0);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        step(); step();

        // Reset pulsed in the return cycle of a CPU read.
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00);
        @(negedge clk);
        chk("rmr_gnt1_pre", int'(bus.gnt1), 0);
        step();
        @(negedge clk);
        chk("rmr_gnt1", int'(bus.gnt1), 1);
        chk("rmr_mem_en", int'(bus.mem_en), 1);
        step();
        bus.req1 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmr_rvalid1_rst", int'(bus.rvalid1), 0);
        chk("rmr_gnt1_rst", int'(bus.gnt1), 0);
        chk("rmr_mem_en_rst", int'(bus.mem_en), 0);
        step();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rmr_rvalid1_post", int'(bus.rvalid1), 0);
            chk("rmr_gnt_post", int'(bus.gnt0 | bus.gnt1), 0);
            step();
        end
        bus.req0 = 1'b1;
        @(negedge clk);
        chk("rmr_idle_gnt0", int'(bus.gnt0), 0);
        step();
        @(negedge clk);
        chk("rmr_gnt0_after", int'(bus.gnt0), 1);
        step();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 16; i++) shadow[i] = ram[i];
        m_owner = -1; m_run = 0; m_last = 1; m_pend = -1; m_pdata = 8'h00; m_hold = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            logic       q0, q1, wq, xf, oq;
            logic [3:0] aq;
            logic [7:0] dq;
            int         nxt;
            if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
            bus.we0    = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.addr0  = 4'($urandom_range(0, 15));
            bus.addr1  = 4'($urandom_range(0, 15));
            bus.wdata0 = 8'($urandom_range(0, 255));
            bus.wdata1 = 8'($urandom_range(0, 255));
            @(negedge clk);
            q0 = bus.req0; q1 = bus.req1;
            oq = (m_owner == 0) ? q0 : q1;
            xf = (m_owner >= 0) && oq;
            wq = (m_owner == 0) ? bus.we0 : bus.we1;
            aq = (m_owner == 0) ? bus.addr0 : bus.addr1;
            dq = (m_owner == 0) ? bus.wdata0 : bus.wdata1;

            chk("rnd_gnt0", int'(bus.gnt0), int'(m_owner == 0));
            chk("rnd_gnt1", int'(bus.gnt1), int'(m_owner == 1));
            chk("rnd_mem_en", int'(bus.mem_en), int'(xf));
            chk("rnd_mem_we", int'(bus.mem_we), xf ? int'(wq) : 0);
            chk("rnd_mem_addr", int'(bus.mem_addr), xf ? int'(aq) : 0);
            chk("rnd_mem_wdata", int'(bus.mem_wdata), xf ? int'(dq) : 0);
            chk("rnd_rvalid0", int'(bus.rvalid0), int'(m_pend == 0));
            chk("rnd_rvalid1", int'(bus.rvalid1), int'(m_pend == 1));
            if (m_pend >= 0) m_hold = m_pdata;
            chk("rnd_rdata", int'(bus.rdata), int'(m_hold));

            // Advance the model by one cycle.
            m_pend = -1;
            if (xf) begin
                if (wq) begin
                    shadow[aq] = dq;
                end else begin
                    m_pend  = m_owner;
                    m_pdata = shadow[aq];
                end
            end
            nxt = m_owner;
            if (m_owner < 0) begin
                if (q0 && q1) nxt = (rr && m_last == 0) ? 1 : 0;
                else if (q0)  nxt = 0;
                else if (q1)  nxt = 1;
            end else if (!oq) begin
                nxt = ((m_owner == 0) ? q1 : q0) ? 1 - m_owner : -1;
            end else if (((m_owner == 0) ? q1 : q0) && m_run + 1 >= MB) begin
                nxt = 1 - m_owner;
            end
            if (xf) m_run++;
            if (nxt != m_owner) begin
                m_run = 0;
                if (nxt >= 0) m_last = nxt;
            end
            m_owner = nxt;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
